// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word requests and queues {instr, pc} for decode.
// Optional macro FETCH_PERF_EN adds saturating pop/redirect performance counters.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_active;
    logic [DATA_W-1:0] r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];

    logic [CNT_W:0]    w_credit_used;
    logic              w_accept;
    logic              w_resp_ok;
    logic              w_resp_drop;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_out_after_resp;
    logic [ADDR_W-1:0] w_redirect_pc;

    // Credits cover both queued entries and in-flight requests, so a response can never find the FIFO full.
    assign w_credit_used    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid   = r_active && !redirect_valid && (w_credit_used < DEPTH_L);
    assign imem_req_addr    = r_fetch_pc;
    assign w_accept         = imem_req_valid && imem_req_ready;
    assign w_resp_ok        = imem_resp_valid && (r_outstanding != '0);
    assign w_resp_drop      = w_resp_ok && (r_drop != '0);
    assign w_push           = w_resp_ok && (r_drop == '0) && !redirect_valid;
    assign instr_valid      = (r_count != '0) && !redirect_valid;
    assign w_pop            = instr_valid && instr_ready;
    assign w_out_after_resp = r_outstanding - CNT_W'(w_resp_ok);
    assign w_redirect_pc    = redirect_pc & ~ADDR_W'(3);

    assign instr    = r_fifo_instr[r_rd_ptr];
    assign instr_pc = r_fifo_pc[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_active <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight after this cycle's response belongs to the old stream.
                r_count       <= '0;
                r_rd_ptr      <= r_wr_ptr;
                r_outstanding <= w_out_after_resp;
                r_drop        <= w_out_after_resp;
                r_fetch_pc    <= w_redirect_pc;
                r_resp_pc     <= w_redirect_pc;
            end else begin
                r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                r_outstanding <= w_out_after_resp + CNT_W'(w_accept);
                r_drop        <= r_drop - CNT_W'(w_resp_drop);
                if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + ADDR_W'(4);
                    r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_resp_data;
            r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [15:0] r_perf_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_pop && (r_perf_fetch_cnt != '1)) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            if (redirect_valid && (r_perf_flush_cnt != '1)) r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

    // A response with nothing outstanding is a memory-side protocol violation; it is ignored above.
    a_resp_has_request : assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model with optional response hold, checks by immediate assertions.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    logic        mem_hold = 1'b0;
    logic [31:0] pend_q[$];
    logic [31:0] acc_q[$];
    int          n_chk = 0;
    int          n_pass = 0;

    fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // In-order memory: one-cycle latency unless mem_hold stalls responses.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q.delete();
            acc_q.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back(imem_req_addr);
                acc_q.push_back(imem_req_addr);
            end
            if (!mem_hold && pend_q.size() != 0) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mem_word(pend_q.pop_front());
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_pop(input logic [31:0] pc);
        bit got;
        got = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (instr_valid) begin
                chk("pop_pc", instr_pc, pc);
                chk("pop_instr", instr, mem_word(pc));
                $display("pop   pc=%08h instr=%08h", instr_pc, instr);
                got = 1'b1;
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
        chk("pop_seen", got, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_hold = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset values, first request, latency and in-order delivery
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        rst_n = 1'b1;
        #1;
        chk("t1_req_valid_c0", imem_req_valid, 0);
        @(negedge clk); #1;
        chk("t1_req_valid_c1", imem_req_valid, 1);
        chk("t1_req_addr_c1", imem_req_addr, 32'h0);
        chk("t1_instr_valid_c1", instr_valid, 0);
        @(negedge clk); #1;
        chk("t1_instr_valid_c2", instr_valid, 0);
        @(negedge clk); #1;
        chk("t1_instr_valid_c3", instr_valid, 1);
        expect_pop(32'h0);
        expect_pop(32'h4);
        expect_pop(32'h8);

        // T2: backpressure from a fresh start -- exactly four requests, head held
        do_reset();
        repeat (10) @(negedge clk);
        #1;
        chk("t2_req_count", acc_q.size(), 4);
        chk("t2_first_addr", acc_q[0], 32'h0);
        chk("t2_last_addr", acc_q[3], 32'hC);
        chk("t2_req_valid", imem_req_valid, 0);
        chk("t2_instr_valid", instr_valid, 1);
        chk("t2_head_pc", instr_pc, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("t2_head_pc_hold", instr_pc, 32'h0);
        chk("t2_head_instr_hold", instr, mem_word(32'h0));
        chk("t2_req_count_hold", acc_q.size(), 4);

        // T4: pop and response in the same cycle keep the count unchanged
        mem_hold = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk); #1;
        instr_ready = 1'b0;
        chk("t4_head_after_pop", instr_pc, 32'h4);
        chk("t4_req_valid_open", imem_req_valid, 1);
        chk("t4_req_addr", imem_req_addr, 32'h10);
        @(negedge clk); #1;
        chk("t4_req_valid_full", imem_req_valid, 0);
        mem_hold = 1'b0;
        @(negedge clk); #1;
        instr_ready = 1'b1;
        mem_hold = 1'b1;
        @(negedge clk); #1;
        instr_ready = 1'b0;
        chk("t4_head_after_both", instr_pc, 32'h8);
        chk("t4_req_valid_one_free", imem_req_valid, 1);
        mem_hold = 1'b0;
        expect_pop(32'h8);
        expect_pop(32'hC);
        expect_pop(32'h10);
        expect_pop(32'h14);

        // T3: redirect with two responses still in flight
        do_reset();
        for (int k = 0; k < 20 && acc_q.size() < 2; k++) @(negedge clk);
        mem_hold = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("t3_req_count", acc_q.size(), 4);
        chk("t3_req_valid_full", imem_req_valid, 0);
        chk("t3_head_pc", instr_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_redir_req_valid", imem_req_valid, 0);
        chk("t3_redir_instr_valid", instr_valid, 0);
        @(negedge clk); #1;
        redirect_valid = 1'b0;
        mem_hold = 1'b0;
        chk("t3_flushed_valid", instr_valid, 0);
        chk("t3_new_addr", imem_req_addr, 32'h100);
        expect_pop(32'h100);
        expect_pop(32'h104);

        // T5: misaligned redirect target near the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        acc_q.delete();
        #1;
        chk("t5_redir_req_valid", imem_req_valid, 0);
        @(negedge clk); #1;
        redirect_valid = 1'b0;
        chk("t5_aligned_addr", imem_req_addr, 32'hFFFF_FFFC);
        repeat (4) @(negedge clk);
        #1;
        chk("t5_two_reqs", acc_q.size() >= 2, 1);
        chk("t5_req0", acc_q[0], 32'hFFFF_FFFC);
        chk("t5_req1_wrap", acc_q[1], 32'h0);
        expect_pop(32'hFFFF_FFFC);
        expect_pop(32'h0);

        // T6: counters, then asynchronous reset in the middle of a cycle
        do_reset();
        expect_pop(32'h0);
        expect_pop(32'h4);
        expect_pop(32'h8);
        expect_pop(32'hC);
        expect_pop(32'h10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 5);
        chk("t6_perf_flush", perf_flush_cnt, 2);
`endif
        for (int k = 0; k < 20 && !instr_valid; k++) begin
            @(negedge clk); #1;
        end
        chk("t6_valid_before_rst", instr_valid, 1);
        chk("t6_head_pc", instr_pc, 32'h300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_instr_valid", instr_valid, 0);
        chk("t6_async_req_valid", imem_req_valid, 0);
        chk("t6_async_instr_pc", instr_pc, 0);
`ifdef FETCH_PERF_EN
        chk("t6_async_perf_fetch", perf_fetch_cnt, 0);
        chk("t6_async_perf_flush", perf_flush_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
